// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads with extension, read-merge-write sub-word stores.
// One outstanding request; strobes and store data are registered.
module load_store_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [7:0]  mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        store_done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, RD, MRG, WR, RSP
  } state_t;

  state_t      state, nxt;
  logic [1:0]  addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        load_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        misalign;
  logic        bad;
  logic [31:0] merged;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign accept = req_valid && req_ready;

  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      size == 2'b01: misalign = Address[0];
      size == 2'b10: misalign = |Address[1:0];
      default:       misalign = 1'b0;
    endcase
    bad = (MemRead == MemWrite) || (size == 2'b11)
       || misalign || (|Address[31:10]);
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && !bad) begin
          if (MemRead)             nxt = RD;
          else if (size == 2'b10)  nxt = WR;
          else                     nxt = RD;
        end
      end
      RD:      nxt = load_q ? RSP : MRG;
      MRG:     nxt = WR;
      WR:      nxt = IDLE;
      RSP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    merged = rdata_q;
    if (size_q == 2'b00) begin
      unique case (addr_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    lane_b = rdata_q[{addr_q, 3'b000} +: 8];
    lane_h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (1'b1)
      size_q == 2'b00:
        load_data = {{24{~uns_q & lane_b[7]}}, lane_b};
      size_q == 2'b01:
        load_data = {{16{~uns_q & lane_h[15]}}, lane_h};
      default:
        load_data = rdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      load_q    <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      state  <= nxt;
      err    <= accept && bad;
      mem_we <= (nxt == WR);
      if (accept) begin
        addr_q  <= Address[1:0];
        size_q  <= size;
        uns_q   <= unsigned_ld;
        load_q  <= MemRead;
        wdata_q <= Write_data[15:0];
        if (!bad) mem_addr <= Address[9:2];
      end
      if (state == IDLE && nxt == WR) mem_wdata <= Write_data;
      if (state == MRG)               mem_wdata <= merged;
      if (state == RD)                rdata_q   <= mem_rdata;
    end
  end

  assign req_ready  = (state == IDLE) && reset_n;
  assign mem_re     = (state == RD);
  assign load_valid = (state == RSP);
  assign store_done = (state == WR);

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  memory request from the execute stage.
- req_ready  out  1  request accepted this cycle when req_valid=1.
- MemRead  in  1  request is a load.
- MemWrite  in  1  request is a store.
- size  in  2  access size: 00=byte, 01=half, 10=word, 11=illegal.
- unsigned_ld  in  1  zero-extend loaded data (byte/half only).
- Address  in  32  byte address.
- Write_data  in  32  store data, right-justified.
- mem_addr  out  8  word index to data memory.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  full word to memory.
- mem_rdata  in  32  word returned by memory.
- load_valid  out  1  one-cycle pulse: load_data is valid.
- load_data  out  32  extended load result.
- store_done  out  1  one-cycle pulse: store committed.
- err  out  1  one-cycle pulse: request rejected.

Function
REQ-002 The block SHALL hold a state machine with states IDLE, RD, MRG, WR and RSP.
REQ-003 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-004 At acceptance, the block SHALL register Address, size, unsigned_ld and Write_data, and mem_addr SHALL take Address[9:2].
REQ-005 The block SHALL reject the request with err=1 on the next cycle, make no memory access and stay in IDLE when any of these holds:
- MemRead equals MemWrite;
- size is 11;
- a half access has Address[0]=1;
- a word access has Address[1:0]≠00;
- Address[31:10] is not zero.
REQ-006 A load SHALL go IDLE→RD (mem_re=1 for one cycle)→RSP→IDLE, and mem_rdata SHALL be captured at the end of RD.
REQ-007 In RSP, load_valid SHALL be 1 for one cycle, so it is high in the 2nd cycle after acceptance.
REQ-008 Byte lanes SHALL be little-endian: the byte at offset k is bits [8k+7:8k]; the half at offset 2 is bits [31:16].
REQ-009 Byte and half loads SHALL be sign-extended unless unsigned_ld=1; for word loads, unsigned_ld SHALL be ignored.
REQ-010 A word store SHALL go IDLE→WR→IDLE, with mem_we=1 and mem_wdata=Write_data for one cycle in WR, and store_done pulsed in that same cycle.
REQ-011 A byte or half store SHALL go IDLE→RD→MRG→WR→IDLE:
- RD reads the old word;
- MRG replaces only the addressed lane(s) with Write_data[7:0] or [15:0];
- WR writes the merged word with store_done=1.
REQ-012 mem_addr, mem_wdata and mem_we SHALL all be registered and SHALL change on the same clock edge.
REQ-013 mem_we and mem_re SHALL never both be 1, and each SHALL be 1 only in the states named above.
REQ-014 load_valid, store_done and err SHALL be mutually exclusive, and each SHALL pulse exactly once per accepted request.
REQ-015 Inputs SHALL be ignored while not in IDLE; back-to-back requests are accepted on the first IDLE cycle.
REQ-016 Boundary addresses SHALL be handled as follows:
- Address 0x3FC SHALL map to index 255;
- Address 0x400 SHALL raise err;
- no mem_addr wrap-around SHALL occur.

Reset
REQ-017 While reset_n=0, the block SHALL asynchronously force state=IDLE and set every output to 0 except req_ready, which SHALL be 0 during reset and 1 in the first cycle after release.
REQ-018 Reset asserted mid-operation SHALL abort the operation: mem_we SHALL drop immediately, no partial write or pulse SHALL be issued afterwards, and latched request fields SHALL be cleared to 0.

Verification
REQ-019 Word store then load: store 0xDEADBEEF at Address 0x010 → mem_we=1 with mem_addr=4 one cycle after acceptance; the load of 0x010 then gives load_valid 2 cycles after acceptance with load_data=0xDEADBEEF.
REQ-020 Byte load extension: the word at index 4 is 0xDEADBEEF; lb at 0x013 → 0xFFFFFFDE; lbu at 0x013 → 0x000000DE; lh at 0x010 → 0xFFFFBEEF; lhu at 0x012 → 0x0000DEAD.
REQ-021 Sub-word store merge: with 0xDEADBEEF at index 4, sb 0x55 at 0x011 → written word 0xDEAD55EF; then sh 0x1234 at 0x012 → 0x123455EF; store_done occurs 3 cycles after acceptance.
REQ-022 Errors: lw at 0x012, sh at 0x001, lw at 0x400, size=11, and MemRead=MemWrite=1 → each gives err=1 one cycle after acceptance, with mem_re=mem_we=0 throughout.
REQ-023 Reset mid-operation: reset_n=0 during the MRG cycle of an sb → outputs go to 0 at once with no write; after release, req_ready=1 and the memory word is unchanged.
